// File: rtl/mem_arb_pkg.sv
// Shared definitions for the I/D line-memory arbiter and the caches that use it.
//   ADDR_W_DEF / DATA_W_DEF : default line address and line data widths
//   state_t                 : arbiter FSM state encoding
//   grant_t                 : which cache currently owns the memory port
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 28;
    localparam int unsigned DATA_W_DEF = 128;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    typedef enum logic {
        GNT_D = 1'b0,
        GNT_I = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant policy for the memory arbiter (purely combinational).
//   i_d_act / i_i_act : D / I cache has a read or write pending
//   i_last_grant      : requester served by the previous grant
//   o_valid_c         : at least one requester is active
//   o_grant_c         : requester to serve next
// FIXED_PRIO=1 always favours D on a tie; otherwise the tie goes to
// whoever was not served last.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic   i_d_act,
    input  logic   i_i_act,
    input  grant_t i_last_grant,
    output logic   o_valid_c,
    output grant_t o_grant_c
);

    always_comb begin
        o_valid_c = i_d_act | i_i_act;
        o_grant_c = GNT_D;
        if (i_d_act && i_i_act) begin
            if (FIXED_PRIO || (i_last_grant == GNT_I)) begin
                o_grant_c = GNT_D;
            end else begin
                o_grant_c = GNT_I;
            end
        end else if (i_i_act) begin
            o_grant_c = GNT_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one line-memory port between the D-cache and I-cache.
//   clk, proc_reset                : clock, async active-high reset
//   d_read/d_write/d_addr/d_wdata  : D-cache request, held until d_ready
//   d_rdata, d_ready               : D-cache read line and completion pulse
//   i_read/i_write/i_addr/i_wdata  : I-cache request, held until i_ready
//   i_rdata, i_ready               : I-cache read line and completion pulse
//   mem_read/mem_write/mem_addr/mem_wdata : registered memory request
//   mem_rdata, mem_ready           : memory read line and completion pulse
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    state_t            r_state, w_state_nxt;
    grant_t            r_grant, w_grant_nxt;
    grant_t            r_last_grant, w_last_grant_nxt;
    logic              r_mem_read, w_mem_read_nxt;
    logic              r_mem_write, w_mem_write_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;

    logic              w_d_act;
    logic              w_i_act;
    logic              w_pick_valid;
    grant_t            w_pick_grant;

    assign w_d_act = d_read | d_write;
    assign w_i_act = i_read | i_write;

    mem_arb_pick #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_pick (
        .i_d_act      (w_d_act),
        .i_i_act      (w_i_act),
        .i_last_grant (r_last_grant),
        .o_valid_c    (w_pick_valid),
        .o_grant_c    (w_pick_grant)
    );

    // State and memory-side request registers
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= GNT_I;
            r_last_grant <= GNT_I;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_mem_read   <= w_mem_read_nxt;
            r_mem_write  <= w_mem_write_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
        end
    end

    // Next-state: arbitrate in IDLE, hold the latched request while BUSY
    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_last_grant_nxt = r_last_grant;
        w_mem_read_nxt   = r_mem_read;
        w_mem_write_nxt  = r_mem_write;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;

        case (r_state)
            ST_IDLE: begin
                w_mem_read_nxt  = 1'b0;
                w_mem_write_nxt = 1'b0;
                if (w_pick_valid) begin
                    w_state_nxt      = ST_BUSY;
                    w_grant_nxt      = w_pick_grant;
                    w_last_grant_nxt = w_pick_grant;
                    // Write wins when a cache raises both strobes
                    if (w_pick_grant == GNT_D) begin
                        w_mem_write_nxt = d_write;
                        w_mem_read_nxt  = d_read & ~d_write;
                        w_mem_addr_nxt  = d_addr;
                        w_mem_wdata_nxt = d_wdata;
                    end else begin
                        w_mem_write_nxt = i_write;
                        w_mem_read_nxt  = i_read & ~i_write;
                        w_mem_addr_nxt  = i_addr;
                        w_mem_wdata_nxt = i_wdata;
                    end
                end
            end
            ST_BUSY: begin
                if (mem_ready) begin
                    w_state_nxt     = ST_IDLE;
                    w_mem_read_nxt  = 1'b0;
                    w_mem_write_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    // Read data goes to both caches; only the owner sees ready
    assign d_rdata = mem_rdata;
    assign i_rdata = mem_rdata;
    assign d_ready = mem_ready & (r_state == ST_BUSY) & (r_grant == GNT_D);
    assign i_ready = mem_ready & (r_state == ST_BUSY) & (r_grant == GNT_I);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter: two cache agents and a memory responder
// feed a transaction-level reference model; a monitor checks the DUT against
// the expected memory requests and ready pulses queued by the model.
module tb_mem_arbiter;

    localparam int unsigned AW         = 28;
    localparam int unsigned DW         = 128;
    localparam bit          FIXED_PRIO = 1'b0;
    localparam int          NCYC       = 4000;

    typedef struct packed {
        logic          act;
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    typedef struct packed {
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int unsigned   cyc;
    } txn_t;

    typedef struct packed {
        logic          who;   // 0 = D, 1 = I
        logic [DW-1:0] data;
    } rdy_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          d_read, d_write, i_read, i_write;
    logic [AW-1:0] d_addr, i_addr;
    logic [DW-1:0] d_wdata, i_wdata;
    logic [DW-1:0] d_rdata, i_rdata;
    logic          d_ready, i_ready;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    txn_t          exp_txn[$];
    rdy_t          exp_rdy[$];
    int            errors = 0;
    int            checks = 0;
    int            n_txn  = 0;
    int unsigned   cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .FIXED_PRIO (FIXED_PRIO)
    ) dut (
        .clk        (clk),
        .proc_reset (rst),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_ready    (d_ready),
        .i_read     (i_read),
        .i_write    (i_write),
        .i_addr     (i_addr),
        .i_wdata    (i_wdata),
        .i_rdata    (i_rdata),
        .i_ready    (i_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic req_t new_req();
        req_t        r;
        int unsigned k;
        k       = $urandom_range(0, 3);   // 0,1 read; 2 write; 3 read+write
        r.act   = 1'b1;
        r.rd    = (k != 2);
        r.wr    = (k >= 2);
        r.addr  = AW'($urandom);
        r.wdata = rand_line();
        return r;
    endfunction

    task automatic drive_pins(input req_t d, input req_t i);
        d_read  = d.act & d.rd;
        d_write = d.act & d.wr;
        d_addr  = d.addr;
        d_wdata = d.wdata;
        i_read  = i.act & i.rd;
        i_write = i.act & i.wr;
        i_addr  = i.addr;
        i_wdata = i.wdata;
    endtask

    // Stimulus, memory responder and reference model
    initial begin
        req_t  rq[2];
        req_t  pin[2];
        txn_t  t;
        rdy_t  r;
        logic  m_busy, m_grant, m_last, done, busy0, w;
        int    cnt;
        bit    did_rst, skip_wait;

        rq[0]       = '0;
        rq[1]       = '0;
        rq[0].act   = 1'b1;
        rq[0].rd    = 1'b1;
        rq[0].addr  = 28'h0000123;
        rq[0].wdata = rand_line();
        rst         = 1'b1;
        mem_ready   = 1'b0;
        mem_rdata   = '0;
        drive_pins(rq[0], rq[1]);
        m_busy    = 1'b0;
        m_grant   = 1'b1;
        m_last    = 1'b1;
        cnt       = 0;
        did_rst   = 1'b0;
        skip_wait = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int n = 0; n < NCYC; n++) begin
            if (!skip_wait) begin
                @(posedge clk);
                #1;
            end
            skip_wait = 1'b0;
            done      = 1'b0;
            busy0     = m_busy;
            mem_ready = 1'b0;

            // Memory: answer the owned transaction after 0..3 extra cycles,
            // otherwise occasionally pulse ready while nothing is pending.
            if (m_busy) begin
                if (cnt == 0) begin
                    done      = 1'b1;
                    mem_ready = 1'b1;
                    mem_rdata = rand_line();
                    r.who     = m_grant;
                    r.data    = mem_rdata;
                    exp_rdy.push_back(r);
                end else begin
                    cnt--;
                end
            end else if ($urandom_range(0, 5) == 0) begin
                mem_ready = 1'b1;
                mem_rdata = rand_line();
            end

            // Caches: hold a request until served; on service optionally
            // chain a follow-on request in the same cycle.
            for (int a = 0; a < 2; a++) begin
                if (done && (m_grant == 1'(a))) begin
                    rq[a] = ($urandom_range(0, 1) == 1) ? new_req() : '0;
                end else if (!rq[a].act && ($urandom_range(0, 2) == 0)) begin
                    rq[a] = new_req();
                end
                pin[a] = rq[a];
                if (m_busy && !done && (m_grant == 1'(a)) && ($urandom_range(0, 2) == 0)) begin
                    pin[a]     = new_req();
                    pin[a].act = 1'($urandom_range(0, 1));
                end
            end
            drive_pins(pin[0], pin[1]);

            // Reference: one owner at a time; ties alternate (or D wins)
            if (!m_busy) begin
                if (rq[0].act || rq[1].act) begin
                    if (rq[0].act && rq[1].act) begin
                        w = FIXED_PRIO ? 1'b0 : ~m_last;
                    end else begin
                        w = rq[1].act;
                    end
                    t.rd    = rq[w].rd & ~rq[w].wr;
                    t.wr    = rq[w].wr;
                    t.addr  = rq[w].addr;
                    t.wdata = rq[w].wdata;
                    t.cyc   = cyc;
                    exp_txn.push_back(t);
                    m_busy  = 1'b1;
                    m_grant = w;
                    m_last  = w;
                    cnt     = int'($urandom_range(0, 3));
                end
            end else if (done) begin
                m_busy = 1'b0;
            end

            // One asynchronous reset in the middle of an owned transaction
            if (!did_rst && (n > NCYC / 2) && busy0 && !done) begin
                #2 rst = 1'b1;
                did_rst = 1'b1;
                drive_pins(rq[0], rq[1]);
                m_busy = 1'b0;
                m_last = 1'b1;
                cnt    = 0;
                exp_txn.delete();
                @(posedge clk);
                @(posedge clk);
                #1 rst = 1'b0;
                skip_wait = 1'b1;
            end
        end

        @(posedge clk);
        #1 mem_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("pending_requests", DW'(exp_txn.size()), DW'(0));
        chk("pending_readies", DW'(exp_rdy.size()), DW'(0));
        chk("activity", DW'(n_txn > 200), DW'(1));
        chk("mid_reset_done", DW'(did_rst), DW'(1));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Monitor: compare DUT outputs with queued expectations
    initial begin
        txn_t cur;
        rdy_t e;
        logic pstb, pmr, stb;
        cur  = '0;
        pstb = 1'b0;
        pmr  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_strobe", DW'({mem_read, mem_write}), DW'(2'b00));
                chk("rst_ready", DW'({d_ready, i_ready}), DW'(2'b00));
                chk("rst_addr", DW'(mem_addr), DW'(0));
                pstb = 1'b0;
                pmr  = 1'b0;
            end else begin
                stb = mem_read | mem_write;
                chk("rw_exclusive", DW'(mem_read & mem_write), DW'(0));
                chk("d_rdata_bcast", d_rdata, mem_rdata);
                chk("i_rdata_bcast", i_rdata, mem_rdata);
                if (pstb && pmr) begin
                    chk("strobe_drop", DW'(stb), DW'(0));
                end
                if (stb && !pstb) begin
                    checks++;
                    if (exp_txn.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_txn at cycle %0d: addr %h with no request expected", cyc, mem_addr);
                    end else begin
                        cur = exp_txn.pop_front();
                        n_txn++;
                        chk("txn_latency", DW'(cyc), DW'(cur.cyc + 1));
                        chk("txn_rw", DW'({mem_read, mem_write}), DW'({cur.rd, cur.wr}));
                        chk("txn_addr", DW'(mem_addr), DW'(cur.addr));
                        chk("txn_wdata", mem_wdata, cur.wdata);
                    end
                end else if (stb) begin
                    chk("hold_rw", DW'({mem_read, mem_write}), DW'({cur.rd, cur.wr}));
                    chk("hold_addr", DW'(mem_addr), DW'(cur.addr));
                    chk("hold_wdata", mem_wdata, cur.wdata);
                end
                if (d_ready || i_ready) begin
                    checks++;
                    if (exp_rdy.size() == 0) begin
                        errors++;
                        $display("FAIL spurious_ready at cycle %0d: d_ready=%0b i_ready=%0b", cyc, d_ready, i_ready);
                    end else begin
                        e = exp_rdy.pop_front();
                        chk("ready_owner", DW'({d_ready, i_ready}), DW'(e.who ? 2'b01 : 2'b10));
                        chk("ready_data", e.who ? i_rdata : d_rdata, e.data);
                    end
                end
                pstb = stb;
                pmr  = mem_ready;
            end
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 128-bit line memory port between the instruction cache and the data cache.
- Each cache sees a private memory port with the same handshake it drives today: mem_read/mem_write and address held until a one-cycle ready pulse.
- The arbiter grants one requester at a time and latches its request into registered memory-side outputs.
- It routes ready to the granted requester only, and broadcasts read data to both.

Parameters:
ADDR_W, 28, line address width (word address minus 2 offset bits)
DATA_W, 128, line width
FIXED_PRIO, 0, 0 = round-robin between requesters on contention; 1 = D always wins ties

Ports:
clk  in  1  clock, rising edge
proc_reset  in  1  asynchronous, active-high reset
d_read  in  1  D-cache line read request
d_write  in  1  D-cache line write-back request
d_addr  in  ADDR_W  D-cache line address
d_wdata  in  DATA_W  D-cache write line
d_rdata  out  DATA_W  read line to D-cache (= mem_rdata)
d_ready  out  1  D-cache completion pulse
i_read  in  1  I-cache line read request
i_write  in  1  I-cache write request (normally tied 0; fully supported)
i_addr  in  ADDR_W  I-cache line address
i_wdata  in  DATA_W  I-cache write line
i_rdata  out  DATA_W  read line to I-cache (= mem_rdata)
i_ready  out  1  I-cache completion pulse
mem_read  out  1  memory read strobe, registered
mem_write  out  1  memory write strobe, registered
mem_addr  out  ADDR_W  registered
mem_wdata  out  DATA_W  registered
mem_rdata  in  DATA_W  memory read line
mem_ready  in  1  memory completion pulse

Behaviour:
- States: IDLE, BUSY. Registers: state, grant (D/I), last_grant, mem_read, mem_write, mem_addr, mem_wdata.
- Reset (async, any cycle): state=IDLE, last_grant=I (so D wins the first tie), all mem_* outputs 0.
  - d_ready and i_ready go low combinationally, because they are gated by state==BUSY.
  - An in-flight memory transaction is abandoned. The memory model must tolerate its strobe dropping.
- A requester is active when read|write is asserted. If both are asserted, write wins: a single strobe is issued with mem_write=1, mem_read=0.
- IDLE, no active requester: stay IDLE; mem_read=mem_write=0; mem_addr/mem_wdata hold their last values.
- IDLE, one active requester: at the next edge, grant it and load mem_read/mem_write/mem_addr/mem_wdata from its inputs. Go to BUSY.
- IDLE, both active:
  - FIXED_PRIO=1: grant D.
  - FIXED_PRIO=0: grant the requester that is not last_grant.
  - Then proceed as for a single requester. last_grant is updated at every grant.
- BUSY:
  - The memory-side registers hold constant. Requester inputs are ignored, so deasserting or changing a request mid-transaction has no effect on memory.
  - Memory read data is broadcast: d_rdata=i_rdata=mem_rdata at all times.
  - d_ready = mem_ready & BUSY & grant==D. i_ready = mem_ready & BUSY & grant==I. Both are combinational, same cycle as mem_ready.
  - On mem_ready: next edge goes to IDLE and clears mem_read/mem_write.
- Latency:
  - Request seen in cycle t → mem strobe high in cycle t+1.
  - mem_ready in cycle k → ready to the cache in cycle k → strobe low in k+1.
  - A follow-on request the cache raises in cycle k (e.g. dirty write-back then refill) is arbitrated in IDLE at k+1, with its strobe at k+2.
  - Minimum 1-cycle bubble between transactions.
- The ungranted requester sees ready=0 and must keep its request asserted. It is served right after the current transaction; round-robin bounds its wait to one transaction.
- mem_ready while IDLE: ignored, no ready pulse to either cache.
- mem_read and mem_write are never high together.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding (IDLE=1'b0, BUSY=1'b1)
  - grant encoding (GNT_D=1'b0, GNT_I=1'b1)
  - ADDR_W/DATA_W defaults, also used by the cache
- One natural sub-module: mem_arb_pick. Combinational; inputs d_act, i_act, last_grant, FIXED_PRIO; outputs a valid bit and grant. Isolates the fairness policy.

Test Plan:
- Reset with d_read=1 held → mem_read=0, mem_addr=0 during reset. First edge after release: mem_read=1, mem_addr=d_addr (0x0000123).
- Lone I read of 0x0000040, memory ready after 3 cycles with mem_rdata=0xDEADBEEF_…_0001 → i_ready pulses once with i_rdata equal to that value. d_ready stays 0. mem_read drops the next cycle.
- d_read and i_read raised in the same cycle, FIXED_PRIO=0, after reset → D served first, then I at ready+1 cycle. Repeated simultaneous requests alternate I, D, I.
- D dirty miss: d_write to 0x00000A0 and i_read both pending; on D's ready the cache switches to d_read 0x00000B0. Expected order: D write, I read, D read. mem_write and mem_read are never both 1.
- Granted D changes d_addr from 0x10 to 0x20 mid-BUSY → mem_addr stays 0x10 until mem_ready.
- Async reset asserted in BUSY, mid-clock → mem_read/mem_write and the ready outputs drop immediately. After release, the pending request is re-arbitrated from IDLE.
